// File: rtl/ifetch_queue.sv
// Instruction fetch queue: credit-limited in-order imem requests, {instr, pc} FIFO to decode, redirect flush.
// Optional IFQ_BYPASS_EN: an empty queue forwards a kept response straight to decode in the same cycle.
module ifetch_queue #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_instr,
  output logic [ADDR_W-1:0] out_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_reg, fetch_pc_next;
  logic [ADDR_W-1:0] resp_pc_reg, resp_pc_next;
  logic [CW-1:0]     inflight_reg, inflight_next;
  logic [CW-1:0]     drop_cnt_reg, drop_cnt_next;
  logic [CW-1:0]     count_reg, count_next;
  logic [PW-1:0]     rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0]     wr_ptr_reg, wr_ptr_next;

  logic [DATA_W-1:0] slot_instr [DEPTH];
  logic [ADDR_W-1:0] slot_pc    [DEPTH];
  logic [DATA_W-1:0] head_instr;
  logic [ADDR_W-1:0] head_pc;

  logic [CW:0] credits_used;
  logic        has_credit;
  logic        issue;
  logic        keep_rsp;
  logic        fifo_empty;
  logic        bypass;
  logic        push;
  logic        pop;

  // Queued entries plus outstanding requests never exceed DEPTH, so a kept response always has a slot.
  assign credits_used = {1'b0, count_reg} + {1'b0, inflight_reg};
  assign has_credit   = credits_used < {1'b0, DEPTH_C};
  assign imem_req     = rst_n & ~redirect & has_credit;
  assign imem_addr    = fetch_pc_reg;
  assign issue        = imem_req & imem_gnt;

  assign fifo_empty = (count_reg == '0);
  assign keep_rsp   = imem_rvalid & (drop_cnt_reg == '0) & ~redirect;
  assign head_instr = slot_instr[rd_ptr_reg];
  assign head_pc    = slot_pc[rd_ptr_reg];

`ifdef IFQ_BYPASS_EN
  assign bypass    = fifo_empty & keep_rsp;
  assign out_valid = rst_n & ~redirect & (~fifo_empty | bypass);
  assign out_instr = !rst_n ? '0 : (bypass ? imem_rdata : head_instr);
  assign out_pc    = !rst_n ? '0 : (bypass ? resp_pc_reg : head_pc);
`else
  assign bypass    = 1'b0;
  assign out_valid = rst_n & ~redirect & ~fifo_empty;
  assign out_instr = rst_n ? head_instr : '0;
  assign out_pc    = rst_n ? head_pc : '0;
`endif

  // A forwarded response that decode takes immediately never occupies a slot.
  assign pop  = out_valid & out_ready & ~fifo_empty;
  assign push = keep_rsp & ~(bypass & out_ready);

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    resp_pc_next  = resp_pc_reg;
    inflight_next = inflight_reg + CW'(issue) - CW'(imem_rvalid);
    drop_cnt_next = drop_cnt_reg;
    count_next    = count_reg + CW'(push) - CW'(pop);
    rd_ptr_next   = rd_ptr_reg + PW'(pop);
    wr_ptr_next   = wr_ptr_reg + PW'(push);

    if (issue) begin
      fetch_pc_next = fetch_pc_reg + ADDR_W'(1);
    end
    if (imem_rvalid) begin
      if (drop_cnt_reg != '0) begin
        drop_cnt_next = drop_cnt_reg - CW'(1);
      end else begin
        resp_pc_next = resp_pc_reg + ADDR_W'(1);
      end
    end

    // Every request still outstanding after this cycle belongs to the old path.
    if (redirect) begin
      fetch_pc_next = redirect_pc;
      resp_pc_next  = redirect_pc;
      drop_cnt_next = inflight_reg - CW'(imem_rvalid);
      count_next    = '0;
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_reg <= '0;
      resp_pc_reg  <= '0;
      inflight_reg <= '0;
      drop_cnt_reg <= '0;
      count_reg    <= '0;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      resp_pc_reg  <= resp_pc_next;
      inflight_reg <= inflight_next;
      drop_cnt_reg <= drop_cnt_next;
      count_reg    <= count_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [DATA_W-1:0] instr_reg;
      logic [ADDR_W-1:0] pc_reg;

      always_ff @(posedge clk) begin
        if (push && (wr_ptr_reg == PW'(gi))) begin
          instr_reg <= imem_rdata;
          pc_reg    <= resp_pc_reg;
        end
      end

      assign slot_instr[gi] = instr_reg;
      assign slot_pc[gi]    = pc_reg;
    end
  endgenerate

  // Memory shares our reset, so a response with nothing outstanding or a push into a full queue is a system fault.
  a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rvalid |-> (inflight_reg != '0));
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    push |-> ((count_reg != DEPTH_C) || pop));

endmodule
